// File: rtl/pattern_seq_gen_if.sv
// pattern_seq_gen_if: table-write, length, control and output signals of the
// pattern sequencer. The master drives writes/control; the slave is the sequencer.
interface pattern_seq_gen_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             len_we;
  logic [LW-1:0]    len_in;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             step;
  logic [WIDTH-1:0] out;
  logic [AW-1:0]    idx;
  logic             active;
  logic             done;
  logic             wrap;

  modport master (
    output wr_en, wr_addr, wr_data, len_we, len_in, start, stop, oneshot, step,
    input  out, idx, active, done, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len_we, len_in, start, stop, oneshot, step,
    output out, idx, active, done, wrap
  );
endinterface

// File: rtl/pattern_seq_gen.sv
// pattern_seq_gen: programmable pattern sequencer. Steps through a writable
// table of WIDTH-bit words, in loop or one-shot mode, presenting the word at
// the current index while running. Table and length can be rewritten at any time.
module pattern_seq_gen #(
  parameter int                   WIDTH       = 1,
  parameter int                   DEPTH       = 8,
  parameter logic [DEPTH*WIDTH-1:0] RST_PATTERN = 8'b0001_0100,
  parameter int                   RST_LEN     = 5,
  parameter bit                   AUTOSTART   = 1'b1
) (
  input logic                clk,
  input logic                rst,
  pattern_seq_gen_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic [LW-1:0]    r_len;
  logic             r_oneshot;
  logic             r_wrap;
  logic             r_active;
  logic             r_done;
  logic [WIDTH-1:0] r_table [DEPTH];

  logic             w_addrOk;
  logic             w_lastStep;
  logic [LW-1:0]    w_lenLoad;

  // Addresses beyond the table are dropped rather than aliased onto real entries.
  assign w_addrOk = 32'(bus.wr_addr) < 32'(DEPTH);

  // The current length (already including any write made this edge earlier) decides
  // the end of the pass, so shrinking below idx makes the very next step wrap/finish.
  assign w_lastStep = (32'(r_idx) + 32'd1) >= 32'(r_len);

  // A zero length is meaningless, so it keeps the old value; oversize lengths clip to DEPTH.
  assign w_lenLoad = (32'(bus.len_in) > 32'(DEPTH)) ? LW'(DEPTH) : bus.len_in;

  // Pattern table: restored to the reset pattern, otherwise written word by word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= RST_PATTERN[i*WIDTH +: WIDTH];
      end
    end else if (bus.wr_en && w_addrOk) begin
      r_table[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sequence length register, loaded independently of the control inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= LW'(RST_LEN);
    end else if (bus.len_we && (bus.len_in != '0)) begin
      r_len <= w_lenLoad;
    end
  end

  // Sequencer FSM with registered status flags; stop beats start, start beats step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= AUTOSTART ? RUN : IDLE;
      r_idx     <= '0;
      r_oneshot <= 1'b0;
      r_wrap    <= 1'b0;
      r_active  <= AUTOSTART;
      r_done    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.stop) begin
        r_state  <= IDLE;
        r_idx    <= '0;
        r_active <= 1'b0;
        r_done   <= 1'b0;
      end else if (bus.start) begin
        r_state   <= RUN;
        r_idx     <= '0;
        r_oneshot <= bus.oneshot;
        r_active  <= 1'b1;
        r_done    <= 1'b0;
      end else if ((r_state == RUN) && bus.step) begin
        if (!w_lastStep) begin
          r_idx <= r_idx + AW'(1);
        end else if (r_oneshot) begin
          r_state  <= DONE;
          r_idx    <= '0;
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_idx  <= '0;
          r_wrap <= 1'b1;
        end
      end
    end
  end

  assign bus.out    = (r_state == RUN) ? r_table[r_idx] : '0;
  assign bus.idx    = r_idx;
  assign bus.active = r_active;
  assign bus.done   = r_done;
  assign bus.wrap   = r_wrap;
endmodule

// File: doc/pattern_seq_gen.md
# pattern_seq_gen

Parametrised, programmable pattern sequencer: steps through a stored table of up to DEPTH WIDTH-bit output words and drives the current word on `out`. Supports loop and one-shot modes, a step enable, start/stop control, and run-time rewriting of both the table and the sequence length. It is the general replacement for fixed hard-coded output-sequence FSMs in the rv32i_quartus design, for uses such as test stimulus, LED/status patterns and simple control strobes. Out of reset with defaults, it produces the looping 5-step sequence 0,0,1,0,1.

## Interface
- `WIDTH`, 1, bits per pattern word.
- `DEPTH`, 8, table entries (≥2); `AW = $clog2(DEPTH)`, `LW = $clog2(DEPTH+1)`.
- `RST_PATTERN`, DEPTH*WIDTH bits, default 8'b0001_0100; entry i = bits [i*WIDTH +: WIDTH].
- `RST_LEN`, 5, sequence length after reset (1..DEPTH).
- `AUTOSTART`, 1, 1 = enter RUN in loop mode when reset releases.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write `wr_data` to table entry `wr_addr`.
- `wr_addr` in AW: table write address.
- `wr_data` in WIDTH: table write data.
- `len_we` in 1: load `len_in` into the length register.
- `len_in` in LW: new sequence length.
- `start` in 1: begin or restart the sequence at index 0.
- `stop` in 1: abort to IDLE.
- `oneshot` in 1: mode sampled on `start`; 1 = single pass, 0 = loop.
- `step` in 1: advance enable, sampled in RUN.
- `out` out WIDTH: current word.
- `idx` out AW: current index.
- `active` out 1: state == RUN.
- `done` out 1: state == DONE.
- `wrap` out 1: one-cycle pulse on loop wrap.

## Operation
- States:
  - IDLE: `out`=0, `idx`=0.
  - RUN: `out` = table[`idx`], read combinationally from registers.
  - DONE: `out`=0, `idx`=0, `done`=1.
- Reset:
  - State = AUTOSTART ? RUN (loop mode) : IDLE.
  - `idx`=0; table = RST_PATTERN; len = RST_LEN.
  - `wrap`=0; `done`=0; `active`=AUTOSTART.
  - `out` = AUTOSTART ? RST_PATTERN entry 0 : 0.
- Control priority, highest first: `rst`, `stop`, `start`, `step`.
- `stop` in any state → IDLE, `idx`=0.
- `start` in any state (no `stop`) → RUN, `idx`=0, latch `oneshot`. Restart while in RUN is legal.
- Step rules in RUN (`step`=1, no `start`/`stop`):
  - `idx` < len-1: `idx`+1.
  - `idx` ≥ len-1, loop mode: `idx`=0 and `wrap` pulses.
  - `idx` ≥ len-1, one-shot mode: → DONE.
- `step`=0: hold state and `idx`.
- Length writes:
  - `len_in`=0 ignored.
  - `len_in` > DEPTH saturates to DEPTH.
  - Takes effect immediately. If `idx` is already ≥ new len-1, the next step wraps or finishes.
- Table writes:
  - Allowed in every state; `wr_addr` ≥ DEPTH ignored.
  - A write to the current `idx` appears on `out` the cycle after the write edge.
- `len_we` and `wr_en` are independent of, and concurrent with, control inputs.
- len=1, loop mode: `idx` stays 0 and `wrap` pulses on every step.

## Timing
- All state, `idx`, table, len and `wrap` are registered.
- `out`, `active` and `done` decode from registers; there is no combinational path from inputs to outputs.
- `start` at edge N: `active`=1, `idx`=0, `out`=table[0] from N+1.
- Each qualifying step advances `idx` one cycle later, so one word is presented per step cycle.
- `wrap` is high exactly the one cycle in which `idx` has returned to 0.
- One-shot: the final word is shown until the last step; `done`=1 from the next cycle until `start`, `stop` or `rst`.
- Reset asserted mid-run: outputs take reset values at the next edge, regardless of other inputs.

## Test plan
- Defaults: release `rst`, hold `step`=1 → `out` = 0,0,1,0,1,0,0,1,… with `wrap` high on each return of `idx` to 0.
- WIDTH=4: write entries 0..2 = 3,7,A; set len=3; `oneshot`=1; pulse `start` → `out` = 3,7,A, then `done`=1, `out`=0, `active`=0.
- `step` gated every other cycle → each word is held for 2 cycles; `idx` sequence is 0,0,1,1,2,2.
- Mid-run `len_in`=2 while `idx`=3 → next step wraps to 0. `len_in`=0 leaves len unchanged; `len_in`=15 reads back as DEPTH.
- `start` and `stop` asserted together in RUN → IDLE, `out`=0. `start` alone at `idx`=3 → `idx`=0 on the next cycle.
- Write the current `idx` entry during RUN with `step`=0 → `out` shows the new value one cycle later. `rst` mid-run → table and len return to RST_PATTERN and RST_LEN.
